// File: rtl/om_pkg.sv
// Shared OM constants, FSM state type and address helper for the OM
// initializer and the update_om read-modify-write block.
package om_pkg;

    localparam int unsigned OM_DEPTH = 4800;
    localparam int unsigned OM_AW    = 13;
    localparam int unsigned OM_DW    = 32;

    localparam logic [OM_DW-1:0] OM_INIT_VAL = 32'h0011EB85;

    typedef enum logic [2:0] {
        DISARM,
        READY,
        RD,
        WAIT,
        CMP
    } om_state_e;

    function automatic logic om_addr_ok(input logic [OM_AW-1:0] addr);
        return addr < OM_AW'(OM_DEPTH);
    endfunction

endpackage

// File: rtl/update_om_if.sv
// Result handshake plus OM RAM port bundle; slave is the update_om side,
// master is the producer/RAM side.
interface update_om_if;
    import om_pkg::*;

    logic             iValid;
    logic [OM_AW-1:0] iAddr;
    logic [OM_DW-1:0] iScore;
    logic             oReady;
    logic [OM_AW-1:0] oAddr_OM;
    logic             oRdreq_OM;
    logic [OM_DW-1:0] iData_from_OM;
    logic             oWrreq_OM;
    logic [OM_DW-1:0] oData_to_OM;

    modport slave (
        input  iValid,
        input  iAddr,
        input  iScore,
        input  iData_from_OM,
        output oReady,
        output oAddr_OM,
        output oRdreq_OM,
        output oWrreq_OM,
        output oData_to_OM
    );

    modport master (
        output iValid,
        output iAddr,
        output iScore,
        output iData_from_OM,
        input  oReady,
        input  oAddr_OM,
        input  oRdreq_OM,
        input  oWrreq_OM,
        input  oData_to_OM
    );

endinterface

// File: rtl/om_rd_delay.sv
// Delays the OM read strobe by RD_LAT cycles to mark when read data is valid.
module om_rd_delay #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iStart,
    output logic oValid
);

    logic [RD_LAT-1:0] sr_q, sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = iStart;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign oValid = sr_q[RD_LAT-1];

endmodule

// File: rtl/update_om.sv
// Keeps the per-window maximum score in OM via a single-outstanding
// read-modify-write per detection result; idle until the initializer is done.
module update_om
    import om_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iInit_done,
    update_om_if.slave  bus,
    output logic        oUpdated,
    output logic        oErr_addr,
    output logic [15:0] oUpd_cnt
);

    om_state_e        state_q, state_d;
    logic             armed_q, armed_d;
    logic             ready_q, ready_d;
    logic             rdreq_q, rdreq_d;
    logic             wrreq_q, wrreq_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic [OM_AW-1:0] addr_q, addr_d;
    logic [OM_DW-1:0] data_q, data_d;
    logic [OM_DW-1:0] score_q, score_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             rd_vld;

    om_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .iClk   (iClk),
        .iReset (iReset),
        .iStart (rdreq_q),
        .oValid (rd_vld)
    );

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        ready_d = 1'b0;
        rdreq_d = 1'b0;
        wrreq_d = 1'b0;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        score_d = score_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            DISARM: begin
                if (iInit_done) begin
                    state_d = READY;
                    armed_d = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            READY: begin
                ready_d = 1'b1;
                if (bus.iValid && ready_q && armed_q) begin
                    ready_d = 1'b0;
                    score_d = bus.iScore;
                    if (om_addr_ok(bus.iAddr)) begin
                        addr_d  = bus.iAddr;
                        rdreq_d = 1'b1;
                        state_d = RD;
                    end else begin
                        // Bad address: flag and spend one idle cycle in CMP, no OM access.
                        err_d   = 1'b1;
                        state_d = CMP;
                    end
                end
            end
            RD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rd_vld) begin
                    state_d = CMP;
                    if (score_q > bus.iData_from_OM) begin
                        wrreq_d = 1'b1;
                        upd_d   = 1'b1;
                        data_d  = score_q;
                        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    end
                end
            end
            CMP: begin
                state_d = READY;
                ready_d = 1'b1;
            end
            default: begin
                state_d = DISARM;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= DISARM;
            armed_q <= 1'b0;
            ready_q <= 1'b0;
            rdreq_q <= 1'b0;
            wrreq_q <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            score_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            ready_q <= ready_d;
            rdreq_q <= rdreq_d;
            wrreq_q <= wrreq_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.oReady      = ready_q;
    assign bus.oRdreq_OM   = rdreq_q;
    assign bus.oWrreq_OM   = wrreq_q;
    assign bus.oAddr_OM    = addr_q;
    assign bus.oData_to_OM = data_q;
    assign oUpdated        = upd_q;
    assign oErr_addr       = err_q;
    assign oUpd_cnt        = cnt_q;

endmodule

// File: tb/tb_update_om.sv
// Scoreboard bench for update_om: OM RAM model plus per-transaction
// expectations queued at accept and retired when the DUT responds.
module tb_update_om;
    import om_pkg::*;

    localparam int unsigned RD_LAT = 2;

    typedef struct {
        logic [OM_AW-1:0] addr;
        logic [OM_DW-1:0] score;
        int               t;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        upd;
    logic        err;
    logic [15:0] cnt;

    update_om_if bus ();

    update_om #(
        .RD_LAT (RD_LAT)
    ) dut (
        .iClk       (clk),
        .iReset     (rst),
        .iInit_done (init_done),
        .bus        (bus),
        .oUpdated   (upd),
        .oErr_addr  (err),
        .oUpd_cnt   (cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // OM RAM model with RD_LAT read pipeline
    logic [OM_DW-1:0] mem     [OM_DEPTH];
    logic [OM_DW-1:0] ref_mem [OM_DEPTH];
    bit               p_v     [RD_LAT];
    logic [OM_AW-1:0] p_a     [RD_LAT];

    initial begin
        for (int i = 0; i < int'(OM_DEPTH); i++) begin
            mem[i]     = OM_INIT_VAL;
            ref_mem[i] = OM_INIT_VAL;
        end
        for (int i = 0; i < int'(RD_LAT); i++) begin
            p_v[i] = 1'b0;
            p_a[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (bus.oWrreq_OM === 1'b1 && bus.oAddr_OM < OM_DEPTH) mem[bus.oAddr_OM] <= bus.oData_to_OM;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            p_v[i] <= p_v[i-1];
            p_a[i] <= p_a[i-1];
        end
        p_v[0] <= (bus.oRdreq_OM === 1'b1);
        p_a[0] <= bus.oAddr_OM;
    end

    assign bus.iData_from_OM = (p_v[RD_LAT-1] && p_a[RD_LAT-1] < OM_DEPTH) ?
                               mem[p_a[RD_LAT-1]] : 32'hDEADBEEF;

    // Scoreboard
    txn_t sbq[$];
    txn_t mx;
    bit   exp_wr;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_acc = 0;
    int   exp_cnt = 0;
    int   ready_due = -1;

    always @(posedge clk) begin
        if (!rst && bus.iValid && bus.oReady === 1'b1) begin
            sbq.push_back('{addr: bus.iAddr, score: bus.iScore, t: cyc});
            acc_cnt++;
            last_acc = cyc;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            exp_cnt   = 0;
            ready_due = -1;
        end else begin
            if (bus.oRdreq_OM && bus.oWrreq_OM) check_eq("rd_wr_excl", 1, 0);
            if (sbq.size() > 0 && sbq[0].addr >= OM_DEPTH && cyc == sbq[0].t + 1) begin
                check_eq("err_pulse", err, 1);
                check_eq("err_no_rd", bus.oRdreq_OM, 0);
                mx = sbq.pop_front();
                ready_due = cyc + 1;
            end else if (err) begin
                check_eq("err_unexp", 1, 0);
            end
            if (bus.oRdreq_OM) begin
                if (sbq.size() == 0) begin
                    check_eq("rd_unexp", 1, 0);
                end else begin
                    check_eq("rd_cyc", cyc, sbq[0].t + 1);
                    check_eq("rd_addr", bus.oAddr_OM, sbq[0].addr);
                end
            end
            if (sbq.size() > 0 && sbq[0].addr < OM_DEPTH && cyc == sbq[0].t + 2 + RD_LAT) begin
                mx = sbq.pop_front();
                exp_wr = mx.score > ref_mem[mx.addr];
                if (exp_wr) begin
                    ref_mem[mx.addr] = mx.score;
                    if (exp_cnt != 65535) exp_cnt++;
                end
                check_eq("wr_strobe", bus.oWrreq_OM, exp_wr);
                check_eq("updated", upd, exp_wr);
                if (exp_wr) begin
                    check_eq("wr_addr", bus.oAddr_OM, mx.addr);
                    check_eq("wr_data", bus.oData_to_OM, mx.score);
                end
                check_eq("upd_cnt", cnt, exp_cnt);
                ready_due = cyc + 1;
            end else if (bus.oWrreq_OM || upd) begin
                check_eq("wr_unexp", 1, 0);
            end
            if (ready_due == cyc) begin
                check_eq("ready_back", bus.oReady, 1);
                ready_due = -1;
            end
        end
    end

    task automatic send(input logic [OM_AW-1:0] a, input logic [OM_DW-1:0] s, input bit hold);
        int start;
        @(negedge clk);
        bus.iValid = 1'b1;
        bus.iAddr  = a;
        bus.iScore = s;
        start = acc_cnt;
        for (int i = 0; i < 50 && acc_cnt == start; i++) begin
            @(posedge clk);
            #1;
        end
        if (acc_cnt == start) check_eq("accept_timeout", 0, 1);
        if (!hold) bus.iValid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) check_eq("idle_timeout", sbq.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
    endtask

    int          t_acc[3];
    logic [31:0] thr_scores[3];

    initial begin
        rst        = 1'b1;
        init_done  = 1'b0;
        bus.iValid = 1'b0;
        bus.iAddr  = '0;
        bus.iScore = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", bus.oReady, 0);
        check_eq("rst_rdreq", bus.oRdreq_OM, 0);
        check_eq("rst_wrreq", bus.oWrreq_OM, 0);
        check_eq("rst_addr", bus.oAddr_OM, 0);
        check_eq("rst_data", bus.oData_to_OM, 0);
        check_eq("rst_cnt", cnt, 0);
        check_eq("rst_upd", upd, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b0;

        // Not armed: results must be ignored
        bus.iValid = 1'b1;
        bus.iAddr  = 13'd3;
        bus.iScore = 32'hFFFFFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("disarm_ready", bus.oReady, 0);
        end
        bus.iValid = 1'b0;

        pulse_init();
        check_eq("arm_ready", bus.oReady, 1);

        send(13'd10, 32'h00200000, 1'b0);
        wait_idle();
        check_eq("cnt_first", cnt, 1);
        send(13'd10, 32'h00100000, 1'b0);
        wait_idle();
        send(13'd10, 32'h00200000, 1'b0);
        wait_idle();
        check_eq("cnt_no_wr", cnt, 1);

        // Init pulse while armed is ignored
        pulse_init();
        @(negedge clk);
        check_eq("init_ign_cnt", cnt, 1);
        check_eq("init_ign_ready", bus.oReady, 1);

        send(13'd4800, 32'hFFFFFFFF, 1'b0);
        wait_idle();
        send(13'd8191, 32'hFFFFFFFF, 1'b0);
        wait_idle();
        send(13'd4799, 32'h12000000, 1'b0);
        wait_idle();
        send(13'd0, 32'h0011EB86, 1'b0);
        wait_idle();

        // Back-to-back accepts with iValid held high
        thr_scores[0] = 32'h00300000;
        thr_scores[1] = 32'h00400000;
        thr_scores[2] = 32'h00500000;
        for (int k = 0; k < 3; k++) begin
            send(13'd5, thr_scores[k], 1'b1);
            t_acc[k] = last_acc;
        end
        bus.iValid = 1'b0;
        wait_idle();
        check_eq("spacing_1", t_acc[1] - t_acc[0], 5);
        check_eq("spacing_2", t_acc[2] - t_acc[1], 5);
        check_eq("mem5_final", mem[5], 32'h00500000);

        for (int k = 0; k < 8; k++) begin
            send(13'(100 + $urandom_range(0, 3)), $urandom, 1'b0);
            wait_idle();
        end

        // Reset during the wait phase aborts the transaction
        send(13'd20, 32'h00900000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("post_rst_ready", bus.oReady, 0);
            check_eq("post_rst_wr", bus.oWrreq_OM, 0);
            @(negedge clk);
        end
        check_eq("mem20_kept", mem[20], OM_INIT_VAL);

        pulse_init();
        send(13'd20, 32'h00900000, 1'b0);
        wait_idle();
        check_eq("cnt_rearm", cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
